expr_sig_capture: RTL and testbench



---
 rtl/expr_sig_pkg.sv | 23 ++
 rtl/expr_sig_fold.sv | 27 ++
 rtl/expr_sig_capture.sv | 125 ++++++++++++
 tb/tb_expr_sig_capture.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/expr_sig_pkg.sv
// Shared types and default constants for the expression-signature capture block.
package expr_sig_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          DEF_Y_W   = 90;
    localparam int          DEF_SIG_W = 32;
    localparam int          DEF_CNT_W = 16;
    localparam logic [31:0] DEF_POLY  = 32'h04C11DB7;
    localparam logic [31:0] DEF_SEED  = 32'hFFFFFFFF;

    // Number of SIG_W-bit chunks a zero-extended Y_W-bit vector splits into.
    function automatic int fold_chunks(input int y_w, input int sig_w);
        return (y_w + sig_w - 1) / sig_w;
    endfunction

    localparam int FOLD_CHUNKS = fold_chunks(DEF_Y_W, DEF_SIG_W);

endpackage

// File: rtl/expr_sig_fold.sv
// Combinational XOR folder: compresses a Y_W-bit vector into one SIG_W-bit word.
module expr_sig_fold
    import expr_sig_pkg::*;
#(
    parameter int Y_W   = DEF_Y_W,
    parameter int SIG_W = DEF_SIG_W
) (
    input  logic [Y_W-1:0]   y,
    output logic [SIG_W-1:0] w
);

    localparam int CHUNKS = fold_chunks(Y_W, SIG_W);

    logic [CHUNKS*SIG_W-1:0] y_ext;

    // NOTE: every always_comb output gets a default before any conditional
    // or loop assignment, so no path can leave it holding a stale value (latch).
    always_comb begin
        y_ext          = '0;
        y_ext[Y_W-1:0] = y;
        w              = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            w = w ^ y_ext[i*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/expr_sig_capture.sv
// Folds accepted result vectors into a MISR signature and compares it after num_vec vectors.
// Optional macro EXPR_SIG_CAPTURE_LASTY_EN adds a last_y output holding the last accepted vector.
module expr_sig_capture
    import expr_sig_pkg::*;
#(
    parameter int               Y_W   = DEF_Y_W,
    parameter int               SIG_W = DEF_SIG_W,
    parameter int               CNT_W = DEF_CNT_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] vec_cnt
`ifdef EXPR_SIG_CAPTURE_LASTY_EN
    ,
    output logic [Y_W-1:0]   last_y
`endif
);

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [SIG_W-1:0] exp_q, exp_d;
    logic             pass_q, pass_d;

    logic [SIG_W-1:0] w;
    logic [SIG_W-1:0] misr_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    expr_sig_fold #(.Y_W(Y_W), .SIG_W(SIG_W)) u_fold (
        .y (in_y),
        .w (w)
    );

    assign accept    = in_valid && (state_q == RUN);
    assign cnt_inc   = cnt_q + 1'b1;
    assign misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ w;

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        exp_d   = exp_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_d = SEED;
                    cnt_d = '0;
                    num_d = num_vec;
                    exp_d = exp_sig;
                    if (num_vec == '0) begin
                        state_d = DONE;
                        pass_d  = (SEED == exp_sig);
                    end else begin
                        state_d = RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    sig_d = misr_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == num_q) begin
                        state_d = DONE;
                        pass_d  = (misr_next == exp_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            num_q   <= '0;
            exp_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

`ifdef EXPR_SIG_CAPTURE_LASTY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_y <= '0;
        else if (accept) last_y <= in_y;
    end
`else
    // Default build folds accepted vectors only; nothing else is retained.
`endif

    assign in_ready = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign sig      = sig_q;
    assign vec_cnt  = cnt_q;

endmodule

// File: tb/tb_expr_sig_capture.sv
// Scoreboard bench for expr_sig_capture: stimulus pushes model expectations, a monitor pops and compares.
module tb_expr_sig_capture;

    localparam logic [31:0] POLY_C = 32'h04C11DB7;
    localparam logic [31:0] SEED_C = 32'hFFFFFFFF;

    typedef struct {
        logic [31:0] sig;
        logic [15:0] cnt;
    } acc_t;

    typedef struct {
        logic [31:0] sig;
        logic        pass;
        logic [15:0] cnt;
    } run_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_vec = '0;
    logic [31:0] exp_sig = '0;
    logic        in_valid = 1'b0;
    logic [89:0] in_y = '0;
    logic        in_ready, busy, done, pass;
    logic [31:0] sig;
    logic [15:0] vec_cnt;

    logic        z_start = 1'b0;
    logic [15:0] z_num_vec = '0;
    logic [31:0] z_exp_sig = '0;
    logic        z_in_valid = 1'b0;
    logic [89:0] z_in_y = '0;
    logic        z_in_ready, z_busy, z_done, z_pass;
    logic [31:0] z_sig;
    logic [15:0] z_vec_cnt;

`ifdef EXPR_SIG_CAPTURE_LASTY_EN
    logic [89:0] last_y, z_last_y;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    acc_t        acc_q[$];
    run_t        run_q[$];
    logic [89:0] preset_y[$];
    bit          preset_v[$];

    always #5 clk = ~clk;

    expr_sig_capture dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_vec  (num_vec),
        .exp_sig  (exp_sig),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .sig      (sig),
        .vec_cnt  (vec_cnt)
`ifdef EXPR_SIG_CAPTURE_LASTY_EN
        ,
        .last_y   (last_y)
`endif
    );

    expr_sig_capture #(.SEED(32'h0)) u_z (
        .clk      (clk),
        .rst      (rst),
        .start    (z_start),
        .num_vec  (z_num_vec),
        .exp_sig  (z_exp_sig),
        .in_valid (z_in_valid),
        .in_ready (z_in_ready),
        .in_y     (z_in_y),
        .busy     (z_busy),
        .done     (z_done),
        .pass     (z_pass),
        .sig      (z_sig),
        .vec_cnt  (z_vec_cnt)
`ifdef EXPR_SIG_CAPTURE_LASTY_EN
        ,
        .last_y   (z_last_y)
`endif
    );

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, expv);
        end
    endtask

    // Reference model: signature as a polynomial shift-register over chunk-XORed data.
    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] w;
        w = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        return (s << 1) ^ (s[31] ? POLY_C : 32'h0) ^ w;
    endfunction

    function automatic logic [89:0] rand_y();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[89:0];
    endfunction

    // Monitor: a sampled accept must show its effect exactly one cycle later.
    bit pending = 1'b0;
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            pending   = 1'b0;
            done_prev = 1'b0;
        end else begin
            check("ready_eq_busy", {95'b0, in_ready}, {95'b0, busy});
            if (pending) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 96'd1, 96'd0);
                end else begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check("acc_sig", {64'b0, sig}, {64'b0, a.sig});
                    check("acc_cnt", {80'b0, vec_cnt}, {80'b0, a.cnt});
                end
            end
            if (done && !done_prev) begin
                if (run_q.size() == 0) begin
                    check("unexpected_done", 96'd1, 96'd0);
                end else begin
                    run_t r;
                    r = run_q.pop_front();
                    check("run_sig", {64'b0, sig}, {64'b0, r.sig});
                    check("run_pass", {95'b0, pass}, {95'b0, r.pass});
                    check("run_cnt", {80'b0, vec_cnt}, {80'b0, r.cnt});
                    check("acc_left_at_done", 96'(acc_q.size()), 96'd0);
                end
            end
            pending   = in_valid && in_ready;
            done_prev = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        acc_q.delete();
        run_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sig"},   {64'b0, sig},      96'd0);
        check({tag, "_cnt"},   {80'b0, vec_cnt},  96'd0);
        check({tag, "_busy"},  {95'b0, busy},     96'd0);
        check({tag, "_done"},  {95'b0, done},     96'd0);
        check({tag, "_pass"},  {95'b0, pass},     96'd0);
        check({tag, "_ready"}, {95'b0, in_ready}, 96'd0);
    endtask

    // One run: model expectations are queued before the DUT sees the start pulse.
    task automatic do_run(input int n, input logic [31:0] exp_in, input bit exp_model,
                          input int pct, input int glitch_at, input int abort_at);
        logic [31:0] ms;
        logic [31:0] ex;
        logic [89:0] ys[$];
        run_t        r;
        int          acc;
        int          cyc;
        bit          v;
        ms = SEED_C;
        for (int k = 0; k < n; k++) begin
            logic [89:0] y;
            y = (preset_y.size() > 0) ? preset_y.pop_front() : rand_y();
            ys.push_back(y);
            ms = misr_step(ms, y);
            acc_q.push_back('{sig: ms, cnt: 16'(k + 1)});
        end
        ex    = exp_model ? ms : exp_in;
        r.sig = ms;
        r.pass = (ms == ex);
        r.cnt = 16'(n);
        run_q.push_back(r);

        start   = 1'b1;
        num_vec = 16'(n);
        exp_sig = ex;
        tick();
        start = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 400) begin
            if (abort_at >= 0 && acc == abort_at) begin
                apply_reset();
                check_zero_outputs("abort");
                return;
            end
            if (glitch_at >= 0 && acc == glitch_at) begin
                start   = 1'b1;
                num_vec = 16'd1;
                exp_sig = ~ex;
                glitch_at = -1;
            end
            v = (preset_v.size() > 0) ? preset_v.pop_front() : ($urandom_range(99) < pct);
            in_valid = v;
            in_y     = v ? ys[acc] : rand_y();
            tick();
            start = 1'b0;
            if (v) acc++;
            cyc++;
        end
        in_valid = 1'b0;
        in_y     = rand_y();
        check("run_done_in_time", {95'b0, done}, 96'd1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();
        check_zero_outputs("idle");
`ifdef EXPR_SIG_CAPTURE_LASTY_EN
        check("reset_last_y", {6'b0, last_y}, 96'd0);
`endif

        // Valid while idle is ignored.
        in_valid = 1'b1;
        in_y     = rand_y();
        tick();
        tick();
        in_valid = 1'b0;
        check_zero_outputs("idle_valid");

        // Single zero vector from SEED gives one polynomial reduction.
        preset_y.push_back(90'h0);
        do_run(1, 32'hFB3EE249, 1'b0, 100, -1, -1);
        check("t1_sig", {64'b0, sig}, {64'b0, 32'hFB3EE249});
        check("t1_pass", {95'b0, pass}, 96'd1);
        check("t1_cnt", {80'b0, vec_cnt}, 96'd1);

        // SEED=0 instance with an all-ones vector.
        z_start   = 1'b1;
        z_num_vec = 16'd1;
        z_exp_sig = 32'h0;
        tick();
        z_start    = 1'b0;
        z_in_valid = 1'b1;
        z_in_y     = {90{1'b1}};
        tick();
        z_in_valid = 1'b0;
        check("t2_sig", {64'b0, z_sig}, {64'b0, 32'h03FFFFFF});
        check("t2_done", {95'b0, z_done}, 96'd1);
        check("t2_pass", {95'b0, z_pass}, 96'd0);

        // Zero-length run completes the cycle after start without ever requesting data.
        apply_reset();
        do_run(0, 32'hFFFFFFFF, 1'b0, 100, -1, -1);
        check("t3_sig", {64'b0, sig}, {64'b0, 32'hFFFFFFFF});
        check("t3_pass", {95'b0, pass}, 96'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_ready_low", {95'b0, in_ready}, 96'd0);
            check("t3_done_held", {95'b0, done}, 96'd1);
        end

        // Gapped valid pattern; accepts only on valid cycles.
        foreach (preset_v[i]) preset_v.delete();
        preset_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_run(4, 32'h0, 1'b1, 100, -1, -1);
        check("t4_cnt", {80'b0, vec_cnt}, 96'd4);

        // Start during RUN is ignored, then reset returns everything to zero.
        do_run(4, 32'h0, 1'b1, 70, 2, -1);
        check("t5_cnt", {80'b0, vec_cnt}, 96'd4);
        apply_reset();
        check_zero_outputs("t5_rst");

`ifdef EXPR_SIG_CAPTURE_LASTY_EN
        preset_y.push_back(90'h1);
        preset_y.push_back(90'h2);
        preset_v = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_run(2, 32'h0, 1'b1, 100, -1, -1);
        check("lasty_done", {6'b0, last_y}, 96'h2);
        tick();
        tick();
        check("lasty_held", {6'b0, last_y}, 96'h2);
`endif

        // Randomized runs, one aborted by a mid-run reset.
        for (int r = 0; r < 25; r++) begin
            if (r == 10) begin
                do_run(6, 32'h0, 1'b1, 60, -1, 3);
            end else begin
                do_run($urandom_range(1, 8), $urandom, 1'($urandom_range(1)),
                       $urandom_range(30, 90), -1, -1);
            end
        end

        tick();
        tick();
        check("acc_q_drained", 96'(acc_q.size()), 96'd0);
        check("run_q_drained", 96'(run_q.size()), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
